// File: rtl/rom_fetch.sv
// rom_fetch: burst fetcher that reads a combinational ROM at pc and hands words out over a valid/ready handshake.
// Define FETCH_PARITY_EN to register even parity alongside byte_out; otherwise parity is tied low.
module rom_fetch #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        len,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [DATA_W-1:0] byte_out,
  output logic [DATA_W/2-1:0] instr,
  output logic [DATA_W/2-1:0] oprnd,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              parity
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [3:0] remaining;
  assign rom_addr = pc;
  assign busy = state != IDLE;
  assign instr = byte_out[DATA_W-1:DATA_W/2];
  assign oprnd = byte_out[DATA_W/2-1:0];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc <= '0;
      remaining <= '0;
      byte_out <= '0;
      fetch_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (load_en) pc <= load_addr;
        if (start) begin
          remaining <= len;
          state <= FETCH;
        end
      end else if (state == FETCH) begin
        byte_out <= rom_data;
        fetch_valid <= 1'b1;
        state <= HOLD;
      end else if (fetch_ready) begin
        fetch_valid <= 1'b0;
        pc <= pc + 1'b1;
        remaining <= (remaining != 4'd0) ? remaining - 1'b1 : remaining;
        state <= (remaining != 4'd0) ? FETCH : IDLE;
        done <= remaining == 4'd0;
      end
    end
  end
`ifdef FETCH_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity <= 1'b0;
    else if (state == FETCH) parity <= ^rom_data;
  end
`else
  assign parity = 1'b0;
`endif
endmodule

// File: tb/tb_rom_fetch.sv
// tb_rom_fetch: directed bursts against a word-level reference model plus literal spot checks.
module tb_rom_fetch;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, load_en = 1'b0, fetch_ready = 1'b0;
  logic [3:0] len = '0;
  logic [11:0] load_addr = '0, rom_addr, pc;
  logic [7:0] rom_data, byte_out;
  logic [3:0] instr, oprnd;
  logic fetch_valid, busy, done, parity;
  logic [7:0] rom [4096];
  int tests = 0, fails = 0;
  bit run = 1'b0;

  rom_fetch dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .load_en(load_en),
    .load_addr(load_addr), .rom_addr(rom_addr), .rom_data(rom_data),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .byte_out(byte_out),
    .instr(instr), .oprnd(oprnd), .pc(pc), .busy(busy), .done(done), .parity(parity)
  );

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  // Word-level model: m_left counts words of the burst not yet accepted.
  logic [11:0] m_pc;
  logic [7:0] m_word;
  logic m_fetch, m_valid, m_done;
  int m_left;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc <= '0; m_left <= 0; m_fetch <= 1'b0; m_valid <= 1'b0; m_word <= '0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (load_en) m_pc <= load_addr;
        if (start) begin
          m_left <= int'(len) + 1;
          m_fetch <= 1'b1;
        end
      end else if (m_fetch) begin
        m_word <= rom[m_pc];
        m_valid <= 1'b1;
        m_fetch <= 1'b0;
      end else if (fetch_ready) begin
        m_valid <= 1'b0;
        m_pc <= m_pc + 12'd1;
        m_left <= m_left - 1;
        m_done <= m_left == 1;
        m_fetch <= m_left != 1;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  logic exp_par;
  always @(negedge clk) if (run) begin
`ifdef FETCH_PARITY_EN
    exp_par = ^m_word;
`else
    exp_par = 1'b0;
`endif
    chk("m_valid", 32'(fetch_valid), 32'(m_valid));
    chk("m_byte", 32'(byte_out), 32'(m_word));
    chk("m_instr", 32'(instr), 32'(m_word[7:4]));
    chk("m_oprnd", 32'(oprnd), 32'(m_word[3:0]));
    chk("m_pc", 32'(pc), 32'(m_pc));
    chk("m_rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("m_busy", 32'(busy), 32'(m_left != 0));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_parity", 32'(parity), 32'(exp_par));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'(i) ^ 8'h5A;
    rom[12'h000] = 8'hA5;
    rom[12'h005] = 8'h11; rom[12'h006] = 8'h22; rom[12'h007] = 8'h33; rom[12'h008] = 8'h44;
    rom[12'h009] = 8'h9C;
    rom[12'h010] = 8'h03;
    rom[12'hFFF] = 8'h07;
    cyc(3);
    run = 1'b1;
    chk("rst_pc", 32'(pc), 0); chk("rst_valid", 32'(fetch_valid), 0);
    chk("rst_byte", 32'(byte_out), 0); chk("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    cyc(1);
    // basic single fetch
    start = 1'b1; len = 4'd0; fetch_ready = 1'b1;
    cyc(1); start = 1'b0;
    chk("t1_busy", 32'(busy), 1); chk("t1_valid_early", 32'(fetch_valid), 0);
    cyc(1);
    chk("t1_valid", 32'(fetch_valid), 1); chk("t1_byte", 32'(byte_out), 32'hA5);
    chk("t1_instr", 32'(instr), 32'hA); chk("t1_oprnd", 32'(oprnd), 32'h5);
    cyc(1);
    chk("t1_pc", 32'(pc), 1); chk("t1_done", 32'(done), 1); chk("t1_valid_off", 32'(fetch_valid), 0);
    cyc(1);
    chk("t1_done_off", 32'(done), 0); chk("t1_idle", 32'(busy), 0);
    // load+start together, four words back to back
    load_en = 1'b1; load_addr = 12'h005; start = 1'b1; len = 4'd3;
    cyc(1); load_en = 1'b0; start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("t2_valid", 32'(fetch_valid), 1);
      chk("t2_byte", 32'(byte_out), 32'(8'h11 * (k + 1)));
      cyc(1);
      chk("t2_gap", 32'(fetch_valid), 0);
    end
    chk("t2_pc", 32'(pc), 32'h009); chk("t2_done", 32'(done), 1);
    cyc(1);
    // backpressure: five stalled cycles then handshake
    start = 1'b1; len = 4'd0; fetch_ready = 1'b0;
    cyc(1); start = 1'b0;
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 32'(fetch_valid), 1);
      chk("t3_hold_byte", 32'(byte_out), 32'h9C);
      chk("t3_hold_pc", 32'(pc), 32'h009);
      cyc(1);
    end
    chk("t3_ignore_start", 32'(busy), 1);
    fetch_ready = 1'b1;
    cyc(1);
    chk("t3_pc", 32'(pc), 32'h00A); chk("t3_done", 32'(done), 1);
    cyc(1);
    // wrap from 0xFFF to 0x000
    load_en = 1'b1; load_addr = 12'hFFF; start = 1'b1; len = 4'd1;
    cyc(1); load_en = 1'b0; start = 1'b0;
    cyc(1);
    chk("t4_byte0", 32'(byte_out), 32'h07);
`ifdef FETCH_PARITY_EN
    chk("t4_parity", 32'(parity), 1);
`else
    chk("t4_parity", 32'(parity), 0);
`endif
    cyc(1);
    chk("t4_pc_wrap", 32'(pc), 32'h000);
    cyc(1);
    chk("t4_byte1", 32'(byte_out), 32'hA5);
    cyc(1);
    chk("t4_pc", 32'(pc), 32'h001); chk("t4_done", 32'(done), 1);
    cyc(1);
    // reset during HOLD
    load_en = 1'b1; load_addr = 12'h010; start = 1'b1; len = 4'd5; fetch_ready = 1'b0;
    cyc(1); load_en = 1'b0; start = 1'b0;
    cyc(1);
    chk("t5_byte", 32'(byte_out), 32'h03); chk("t5_parity", 32'(parity), 0);
    #1 reset = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(fetch_valid), 0); chk("t5_rst_byte", 32'(byte_out), 0);
    chk("t5_rst_pc", 32'(pc), 0); chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_done", 32'(done), 0); chk("t5_rst_parity", 32'(parity), 0);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    chk("t5_no_done", 32'(done), 0);
    start = 1'b1; len = 4'd0; fetch_ready = 1'b1;
    cyc(1); start = 1'b0;
    cyc(1);
    chk("t5_refetch", 32'(byte_out), 32'hA5);
    cyc(1);
    chk("t5_done", 32'(done), 1);
    cyc(2);
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
